// File: rtl/ab_pkg.sv
// Shared definitions for the a*root(b) datapath: root-mode encoding, FSM state
// encoding, and the digit-iteration count as a function of operand width and mode.
// No ports; imported by iroot_seq and ab_root_mul.
package ab_pkg;

    localparam logic MODE_CBRT = 1'b0;
    localparam logic MODE_SQRT = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROOT = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    // One root digit per iteration: ceil(w/3) digits for cube, ceil(w/2) for square.
    function automatic int unsigned root_iters(input int unsigned w, input logic mode);
        return (mode == MODE_SQRT) ? (w + 1) / 2 : (w + 2) / 3;
    endfunction

endpackage

// File: rtl/iroot_seq.sv
// Digit-serial integer root: floor(cbrt(b)) or floor(sqrt(b)), one result bit per cycle, MSB first.
// Ports: clk_i, rst_i (async high), start_i/mode_i/b_i (captured when idle),
//        busy_o (high for the iteration cycles), root_o (RW-bit root, valid once busy_o falls).
module iroot_seq #(
    parameter int W  = 8,
    parameter int RW = (W + 1) / 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [W-1:0]  b_i,
    output logic          busy_o,
    output logic [RW-1:0] root_o
);
    import ab_pkg::*;

    localparam int CW = $clog2(W + 1);
    // Trial values are formed well wider than the radicand so no shift can wrap.
    localparam int TW = 3 * W + 4;
    localparam logic [CW-1:0] LAST_CBRT = CW'(root_iters(W, MODE_CBRT) - 1);
    localparam logic [CW-1:0] LAST_SQRT = CW'(root_iters(W, MODE_SQRT) - 1);

    logic [W-1:0]  rem_q,  rem_d;
    logic [RW-1:0] y_q,    y_d;
    logic [CW-1:0] s_q,    s_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;

    logic [TW-1:0] y2_w, base_w, trial_w, rem_w;
    logic [CW+1:0] sh;
    logic          take;

    // y2 is the doubled partial root. Square step subtracts (2*y2+1) << 2s,
    // cube step subtracts (3*y2*(y2+1)+1) << 3s, i.e. the growth of the power
    // when the new low bit is set.
    always_comb begin
        y2_w    = TW'(y_q) << 1;
        sh      = mode_q ? {1'b0, s_q, 1'b0} : ({2'b00, s_q} + {1'b0, s_q, 1'b0});
        base_w  = mode_q ? ((y2_w << 1) + TW'(1))
                         : (TW'(3) * y2_w * (y2_w + TW'(1)) + TW'(1));
        trial_w = base_w << sh;
        rem_w   = TW'(rem_q);
        take    = (rem_w >= trial_w);
    end

    always_comb begin
        rem_d  = rem_q;
        y_d    = y_q;
        s_d    = s_q;
        mode_d = mode_q;
        busy_d = busy_q;
        if (busy_q) begin
            if (take) begin
                rem_d = rem_q - W'(trial_w);
                y_d   = RW'(y2_w + TW'(1));
            end else begin
                y_d   = RW'(y2_w);
            end
            if (s_q == '0) busy_d = 1'b0;
            else           s_d    = s_q - CW'(1);
        end else if (start_i) begin
            rem_d  = b_i;
            y_d    = '0;
            mode_d = mode_i;
            s_d    = (mode_i == MODE_SQRT) ? LAST_SQRT : LAST_CBRT;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            y_q    <= '0;
            s_q    <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            y_q    <= y_d;
            s_q    <= s_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign root_o = y_q;

endmodule

// File: rtl/ab_root_mul.sv
// y = a * floor(root(b)), cube or square root per transaction; fixed latency NR + W + 2 cycles.
// Ports: clk_i, rst_i (async high), start_i (sampled in IDLE), mode_i, a_i, b_i,
//        busy_o (accept edge to result edge), done_o (1-cycle pulse), y_bo (held until next accept).
module ab_root_mul #(
    parameter int W  = 8,
    parameter int RW = (W + 1) / 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           mode_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] y_bo
);
    import ab_pkg::*;

    localparam int CW = $clog2(W + 1);

    logic [1:0]     state_q,  state_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] mcand_q,  mcand_d;
    logic [2*W-1:0] acc_q,    acc_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [2*W-1:0] y_q,      y_d;
    logic           busy_q,   busy_d;
    logic           done_q,   done_d;

    logic           root_go;
    logic           root_busy;
    logic [RW-1:0]  root;

    // The root unit captures b and mode on the same edge the FSM captures a.
    assign root_go = (state_q == ST_IDLE) && start_i;

    iroot_seq #(.W(W), .RW(RW)) u_root (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (root_go),
        .mode_i  (mode_i),
        .b_i     (b_i),
        .busy_o  (root_busy),
        .root_o  (root)
    );

    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mplier_d = a_i;
                    acc_d    = '0;
                    y_d      = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_ROOT;
                end
            end
            ST_ROOT: begin
                // root_busy rises on the accept edge, so it is already high on the first ROOT cycle.
                if (!root_busy) begin
                    mcand_d = {{(2*W-RW){1'b0}}, root};
                    cnt_d   = CW'(W - 1);
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) state_d = ST_FIN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_FIN: begin
                y_d     = acc_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_bo   = y_q;

endmodule

// File: tb/tb_ab_root_mul.sv
// Bench for ab_root_mul at W=8 and W=16: directed vector table, handshake corner
// sequences, asynchronous reset abort, and a W=16 sweep against a brute-force root model.
module tb_ab_root_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] a = '0, b = '0;

    logic        busy8, done8, busy16, done16;
    logic [15:0] y8;
    logic [31:0] y16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ab_root_mul #(.W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .mode_i(mode),
        .a_i(a[7:0]), .b_i(b[7:0]), .busy_o(busy8), .done_o(done8), .y_bo(y8)
    );

    ab_root_mul #(.W(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .mode_i(mode),
        .a_i(a), .b_i(b), .busy_o(busy16), .done_o(done16), .y_bo(y16)
    );

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        longint      exp_y;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint ref_root(input longint v, input logic m);
        longint r = 0;
        while (((r + 1) * (r + 1) * (m ? 64'sd1 : (r + 1))) <= v) r++;
        return r;
    endfunction

    // Current state of the selected DUT.
    function automatic logic get_busy(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction
    function automatic logic get_done(input bit w16);
        return w16 ? done16 : done8;
    endfunction
    function automatic longint get_y(input bit w16);
        return w16 ? longint'(y16) : longint'(y8);
    endfunction

    // Entered and left 1 time unit after a rising edge. Issues one op, measures the
    // number of edges from acceptance to done_o, and checks busy/done framing.
    task automatic run_op(input string name, input bit w16, input logic m,
                          input logic [15:0] av, input logic [15:0] bv,
                          input longint exp_y, input int exp_lat);
        int  lat = -1;
        bit  busy_gap = 0;
        mode = m; a = av; b = bv;
        if (w16) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        check({name, " busy_at_accept"}, get_busy(w16), 1);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (get_done(w16)) begin
                lat = n;
                break;
            end
            if (!get_busy(w16)) busy_gap = 1;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " y"}, get_y(w16), exp_y);
        check({name, " busy_gap"}, busy_gap, 0);
        @(posedge clk); #1;
        check({name, " done_single"}, get_done(w16), 0);
    endtask

    vec_t vt[$];

    initial begin
        int  lat;
        int  done_cnt;
        bit  busy_drop;
        longint ey;
        logic [15:0] ra, rb;

        vt.push_back('{1'b0, 16'd5,   16'd27,  15,   13});
        vt.push_back('{1'b0, 16'd255, 16'd255, 1530, 13});
        vt.push_back('{1'b1, 16'd200, 16'd255, 3000, 14});
        vt.push_back('{1'b0, 16'd77,  16'd0,   0,    13});
        vt.push_back('{1'b1, 16'd77,  16'd0,   0,    14});
        vt.push_back('{1'b0, 16'd0,   16'd64,  0,    13});
        vt.push_back('{1'b1, 16'd10,  16'd100, 100,  14});
        vt.push_back('{1'b0, 16'd9,   16'd8,   18,   13});
        vt.push_back('{1'b0, 16'd100, 16'd63,  300,  13});
        vt.push_back('{1'b1, 16'd255, 16'd1,   255,  14});
        vt.push_back('{1'b1, 16'd1,   16'd224, 14,   14});
        vt.push_back('{1'b0, 16'd200, 16'd125, 1000, 13});
        vt.push_back('{1'b1, 16'd3,   16'd3,   3,    14});

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst busy8", busy8, 0);
        check("rst done8", done8, 0);
        check("rst y8", y8, 0);
        check("rst busy16", busy16, 0);
        check("rst y16", y16, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table at W=8.
        foreach (vt[i])
            run_op($sformatf("vec%0d", i), 1'b0, vt[i].mode, vt[i].a, vt[i].b,
                   vt[i].exp_y, vt[i].exp_lat);

        // Start held high, operands toggled mid-op, back-to-back accept after done.
        mode = 1'b0; a = 16'd3; b = 16'd8; start8 = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            case (n)
                2: begin a = 16'd200; b = 16'd1;   mode = 1'b1; end
                5: begin a = 16'd17;  b = 16'd100; mode = 1'b0; end
                9: begin a = 16'd255; b = 16'd255; mode = 1'b1; end
                default: ;
            endcase
            @(posedge clk); #1;
            if (done8) begin
                lat = n;
                break;
            end
        end
        check("hold lat", lat, 13);
        check("hold y", y8, 6);
        // done_o is high now with start still high: the next edge accepts.
        @(posedge clk); #1;
        check("b2b busy", busy8, 1);
        check("b2b y_cleared", y8, 0);
        a = 16'd1; b = 16'd1; mode = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == 3) start8 = 1'b0;
            @(posedge clk); #1;
            if (done8) begin
                lat = n;
                break;
            end
        end
        check("b2b lat", lat, 14);
        check("b2b y", y8, 3825);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an op.
        mode = 1'b0; a = 16'd5; b = 16'd27; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst busy", busy8, 0);
        check("arst y", y8, 0);
        check("arst done", done8, 0);
        #2 rst = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done8) done_cnt++;
        end
        check("arst no_done", done_cnt, 0);
        run_op("after_arst", 1'b0, 1'b0, 16'd5, 16'd27, 15, 13);

        // W=16.
        run_op("w16 cube", 1'b1, 1'b0, 16'd1000, 16'd65535, 40000, 24);
        run_op("w16 sqrt", 1'b1, 1'b1, 16'd65535, 16'd65535, 65535 * 255, 26);
        for (int i = 0; i < 24; i++) begin
            logic m;
            m  = logic'(i % 2);
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            ey = longint'(ra) * ref_root(longint'(rb), m);
            run_op($sformatf("rnd%0d a=%0d b=%0d m=%0d", i, ra, rb, m), 1'b1, m, ra, rb,
                   ey, m ? 26 : 24);
        end

        // Start raised during busy is ignored and does not disturb the op.
        mode = 1'b1; a = 16'd10; b = 16'd49; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 16'd99; b = 16'd200; mode = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        busy_drop = 0;
        for (int n = 5; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = n;
                break;
            end
            if (!busy8) busy_drop = 1;
        end
        check("busy_start lat", lat, 14);
        check("busy_start y", y8, 70);
        check("busy_start gap", busy_drop, 0);
        @(posedge clk); #1;
        check("busy_start no_requeue", busy8, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
